// File: rtl/imem_fetch_port.sv
// ----------------------------------------------------------------------------
// imem_fetch_port
//   Parametrised instruction memory for the MIPS core. It sits between the
//   PC/fetch stage and decode. It provides:
//   - a handshaked fetch port with a registered 1-cycle read,
//   - a one-entry response buffer that holds its word under backpressure,
//   - a word-write load port for program download,
//   - a toggle output that flips on every accepted fetch.
//
//   Build option: define IMEM_FAULT_EN to flag misaligned or out-of-range PCs.
//   With IMEM_FAULT_EN defined, a faulting fetch returns NOP_WORD with
//   resp_fault_o=1 and does not read the array. Without it, the byte offset is
//   ignored and the address wraps modulo DEPTH*4.
//
//   The array has no reset and no power-up image. It must be filled through
//   the load port before use.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         synchronous reset, active low
//   req_valid_i    fetch request present
//   req_ready_o    request accepted when req_valid_i & req_ready_o
//   req_pc_i       byte address of the instruction
//   resp_valid_o   response word present
//   resp_ready_i   consumer takes the response when resp_valid_o & resp_ready_i
//   resp_instr_o   fetched instruction
//   resp_pc_o      PC that produced resp_instr_o
//   resp_fault_o   address fault (always 0 without IMEM_FAULT_EN)
//   ld_en_i        write ld_data_i into word ld_addr_i this cycle
//   ld_addr_i      word index for the load port
//   ld_data_i      word to store
//   fetch_toggle_o inverts on every accepted fetch request
// ----------------------------------------------------------------------------
module imem_fetch_port #(
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      DEPTH    = 256,
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0,
    localparam int unsigned     IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_pc_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_instr_o,
    output logic [ADDR_W-1:0] resp_pc_o,
    output logic              resp_fault_o,
    input  logic              ld_en_i,
    input  logic [IDX_W-1:0]  ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              fetch_toggle_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_instr_q, resp_instr_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic              resp_fault_q, resp_fault_d;
    logic              toggle_q, toggle_d;

    logic              accept;
    logic              fault;
    logic [IDX_W-1:0]  rd_idx;

    assign rd_idx = req_pc_i[2 +: IDX_W];

`ifdef IMEM_FAULT_EN
    // Out of range means any address bit above the word index is set.
    assign fault = (req_pc_i[1:0] != 2'b00) || (req_pc_i[ADDR_W-1:IDX_W+2] != '0);
`else
    // Offset and upper bits are discarded, so the address wraps.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc_i[1:0], req_pc_i[ADDR_W-1:IDX_W+2]};
    assign fault          = 1'b0;
`endif

    // The slot is free when it is empty or is drained this cycle. This keeps
    // back-to-back fetches free of bubbles.
    assign req_ready_o = rst_ni & (~resp_valid_q | resp_ready_i);
    assign accept      = req_valid_i & req_ready_o;

    // The load port is ignored during reset. The fetch path below reads mem_q
    // before this write takes effect, so a same-cycle fetch returns the old word.
    always_ff @(posedge clk_i) begin
        if (rst_ni && ld_en_i) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_instr_d = resp_instr_q;
        resp_pc_d    = resp_pc_q;
        resp_fault_d = resp_fault_q;
        toggle_d     = toggle_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_instr_d = fault ? NOP_WORD : mem_q[rd_idx];
            resp_pc_d    = req_pc_i;
            resp_fault_d = fault;
            toggle_d     = ~toggle_q;
        end else if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_instr_q <= NOP_WORD;
            resp_pc_q    <= '0;
            resp_fault_q <= 1'b0;
            toggle_q     <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_instr_q <= resp_instr_d;
            resp_pc_q    <= resp_pc_d;
            resp_fault_q <= resp_fault_d;
            toggle_q     <= toggle_d;
        end
    end

    assign resp_valid_o   = resp_valid_q;
    assign resp_instr_o   = resp_instr_q;
    assign resp_pc_o      = resp_pc_q;
    assign resp_fault_o   = resp_fault_q;
    assign fetch_toggle_o = toggle_q;

endmodule
